stage_sequencer: RTL
====================

Name: stage_sequencer

Overview:
- Parametrised multicycle stage controller for the CPU datapath. It generalises the fixed five-state fetch/regfetch/execute/memory/writeback loop.
- Drives one-hot per-stage enable strobes to the pipeline registers.
- Adds per-stage stall handshakes, per-instruction stage skipping, flush (branch restart), run/halt control and a retired-instruction counter.

Parameters:
- NUM_STAGES, 5, number of sequenced stages; stage 0 is instruction fetch. Legal range 2..16.
- STAGE_BITS, 3, width of the stage index; must satisfy 2^STAGE_BITS >= NUM_STAGES.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- nreset  input  1  reset, asynchronous, active-high; forces the reset state immediately.
- run  input  1  sequencing enable; sampled only at instruction boundaries.
- stage_busy  input  NUM_STAGES  per-stage stall request; bit k holds the sequencer in stage k.
- skip_mask  input  NUM_STAGES  stages to bypass for the current instruction; valid while in stage 0; bit 0 ignored.
- flush  input  1  abort the current instruction and restart at stage 0.
- stage_go  output  NUM_STAGES  registered one-hot enable of the active stage; all zero when idle.
- stage_idx  output  STAGE_BITS  registered binary index of the active stage; 0 when idle.
- instr_done  output  1  registered one-cycle pulse per retired instruction.
- instr_count  output  CNT_WIDTH  retired-instruction count; wraps modulo 2^CNT_WIDTH.
- idle  output  1  high in IDLE state.

Behaviour:
- Reset (asynchronous, no clock needed) sets:
  - state=IDLE, stage_go=0, stage_idx=0
  - instr_done=0, instr_count=0, idle=1
  - latched skip mask=0
- State machine: IDLE and ACTIVE(k), k=0..NUM_STAGES-1. Exactly one stage_go bit is high in ACTIVE; stage_go[k] corresponds to stage_idx=k.
- IDLE:
  - run=1 -> ACTIVE(0) next edge.
  - run=0 -> stay in IDLE.
  - flush is ignored in IDLE.
- ACTIVE(k), priority order:
  - flush=1 (overrides stage_busy): next edge -> ACTIVE(0) if run=1, else IDLE. No instr_done, no count change, latched skip mask cleared.
  - Else stage_busy[k]=1: hold ACTIVE(k); all outputs unchanged.
  - Else advance to the lowest j>k whose effective skip bit is 0.
- Effective skip bits:
  - When leaving stage 0, the live skip_mask is used.
  - skip_mask is latched with bit 0 forced to 0 on that same edge.
  - Later stages use the latched mask.
- Completion: if no such j exists, the instruction completes on that edge:
  - instr_done=1 for the following cycle only.
  - instr_count increments on the same edge; all-ones wraps to 0.
  - Next state is ACTIVE(0) if run=1, else IDLE (idle=1 in that same cycle).
- Latency: an instruction with no skips and no stalls occupies exactly NUM_STAGES cycles. Each skipped stage removes one cycle; each stalled cycle adds one.
- A skip_mask with all bits 1..NUM_STAGES-1 set completes the instruction after one cycle in stage 0.
- run=0 mid-instruction does not abort; the instruction finishes, then the sequencer enters IDLE.
- Flush while in stage 0 restarts stage 0 (one more stage-0 cycle).
- Flush on the completion edge takes priority: the instruction is not counted.
- Reset mid-instruction abandons it; no done pulse, count cleared.
- stage_busy bits for non-active stages are ignored.

Test Plan:
- NUM_STAGES=5, run=1, skip_mask=0, stage_busy=0 after reset:
  - -> stage_go steps 00001,00010,00100,01000,10000 then back to 00001.
  - -> instr_done=1 in that cycle and instr_count=1.
  - -> repeats every 5 cycles.
- skip_mask=5'b01000 presented in stage 0, cleared afterwards:
  - -> stage_idx sequence 0,1,2,4.
  - -> instr_done after 4 cycles; the next instruction takes 5 cycles again.
- stage_busy[2]=1 for 3 cycles after entering stage 2:
  - -> stage_go=00100 held 4 cycles; instruction takes 8 cycles, count+1.
- flush=1 for one cycle in stage 3:
  - -> next cycle stage_go=00001.
  - -> instr_done stays 0 and instr_count unchanged.
  - -> flush together with stage_busy[3]=1 gives the same result.
- run dropped to 0 while in stage 2:
  - -> stages 3,4 execute, instr_done pulses, count+1.
  - -> then stage_go=0, idle=1 until run=1, which re-enters stage 0 next edge.
- CNT_WIDTH=4: run 16 instructions -> instr_count returns to 0.
- nreset pulsed asynchronously mid-stage-3 (between clock edges):
  - -> stage_go=0, idle=1, instr_count=0 immediately without a clock edge.

Source files
------------

// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer: one-hot stage strobes with stall, skip, flush, run/halt and retire count.
// One cycle per visited stage; stage_busy[k] holds stage k in place, flush restarts at stage 0.
module stage_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int STAGE_BITS = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  run,
    input  logic [NUM_STAGES-1:0] stage_busy,
    input  logic [NUM_STAGES-1:0] skip_mask,
    input  logic                  flush,
    output logic [NUM_STAGES-1:0] stage_go,
    output logic [STAGE_BITS-1:0] stage_idx,
    output logic                  instr_done,
    output logic [CNT_WIDTH-1:0]  instr_count,
    output logic                  idle
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [NUM_STAGES-1:0] GO_FETCH = {{(NUM_STAGES-1){1'b0}}, 1'b1};

    state_t                  state;
    logic [NUM_STAGES-1:0]   latchedSkip;
    logic [NUM_STAGES-1:0]   effSkip;
    logic                    nextFound;
    logic [STAGE_BITS-1:0]   nextIdx;

    // Fetch sees the live mask; later stages use the copy taken when fetch was left.
    always_comb begin
        effSkip   = (stage_idx == '0) ? (skip_mask & ~GO_FETCH) : latchedSkip;
        nextFound = 1'b0;
        nextIdx   = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (!nextFound && (STAGE_BITS'(j) > stage_idx) && !effSkip[j]) begin
                nextFound = 1'b1;
                nextIdx   = STAGE_BITS'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            state       <= IDLE;
            stage_go    <= '0;
            stage_idx   <= '0;
            instr_done  <= 1'b0;
            instr_count <= '0;
            idle        <= 1'b1;
            latchedSkip <= '0;
        end else begin
            instr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state     <= ACTIVE;
                        stage_go  <= GO_FETCH;
                        stage_idx <= '0;
                        idle      <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (flush || (!stage_busy[stage_idx] && !nextFound)) begin
                        // Flush and completion both return to fetch or idle; only completion retires.
                        latchedSkip <= '0;
                        if (!flush) begin
                            instr_done  <= 1'b1;
                            instr_count <= instr_count + CNT_WIDTH'(1);
                        end
                        stage_idx <= '0;
                        if (run) begin
                            stage_go <= GO_FETCH;
                            idle     <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            stage_go <= '0;
                            idle     <= 1'b1;
                        end
                    end else if (!stage_busy[stage_idx]) begin
                        if (stage_idx == '0) begin
                            latchedSkip <= effSkip;
                        end
                        stage_idx <= nextIdx;
                        stage_go  <= GO_FETCH << nextIdx;
                    end
                end
                default: begin
                    state    <= IDLE;
                    stage_go <= '0;
                    idle     <= 1'b1;
                end
            endcase
        end
    end

endmodule
